iob_timer_mc: RTL
=================

# iob_timer_mc

Multi-channel programmable timer for the IOb peripheral bus, successor to the single free-running timer. Provides N_CH independent up-counters, each with its own prescaler, compare register, one-shot/periodic mode, sticky match flag and interrupt output. Sits behind the CPU native valid/ready interface alongside the other IOb peripherals; all channels share one clock domain.

## Interface
- N_CH, 4: number of timer channels (1..16).
- COUNTER_WIDTH, 32: counter, compare and data bus width (16..64).
- PRESCALE_W, 16: prescaler register width (≤ COUNTER_WIDTH).
- ADDR_W, $clog2(N_CH)+3 (derived, not overridden): address width; addr = {channel index, 3-bit register offset}.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  bus request strobe.
- addr  in  ADDR_W  register address.
- wr  in  1  1 = write, 0 = read; sampled with valid.
- data_in  in  COUNTER_WIDTH  write data.
- data_out  out  COUNTER_WIDTH  read data; registered.
- ready  out  1  one-cycle acknowledge.
- irq  out  N_CH  per-channel interrupt, level, registered.

## Operation
- Per-channel registers (offset): 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS, 4 PRESCALE; 5–7 reserved (read 0, writes ignored). Channel index ≥ N_CH: reads 0, writes ignored, ready still returned.
- CTRL bits: [0] EN, [1] PERIODIC (1 periodic, 0 one-shot), [2] IRQ_EN, [3] CLR (write-only pulse, reads 0). Other bits read 0.
- CLR=1 write: counter and prescaler to 0 next cycle; EN/PERIODIC/IRQ_EN take the written values in the same write; COMPARE, PRESCALE, STATUS untouched.
- Prescaler: counts 0..PRESCALE while EN=1; tick when prescaler == PRESCALE, then prescaler returns to 0. Counter advances once per PRESCALE+1 cycles; PRESCALE=0 → tick every cycle. Prescaler is held (not cleared) while EN=0.
- On tick: if counter == COMPARE → STATUS.MATCH set; PERIODIC=1 → counter to 0; PERIODIC=0 → counter holds at COMPARE and EN clears. Otherwise counter + 1, modulo 2^COUNTER_WIDTH (wraps silently, no flag).
- COMPARE below current counter: counter wraps through 2^COUNTER_WIDTH−1 → 0 before matching.
- COUNT write: loads counter directly, overrides any same-cycle increment or periodic reload; prescaler unchanged.
- STATUS: bit0 MATCH, sticky; write 1 to bit0 clears. Set and clear in the same cycle → set wins.
- irq[ch] = registered (MATCH & IRQ_EN).
- Reset values: all counters, prescalers, COMPARE, PRESCALE, CTRL, STATUS = 0; data_out = 0; ready = 0; irq = 0.

## Timing
- Every valid cycle gets ready=1 on the following cycle; back-to-back valid allowed (ready continuous). No wait states.
- Read: data_out valid in the ready cycle, holds until the next read response; reflects register state at the valid cycle.
- Write: register updated at the valid-cycle clock edge; new value readable by a read issued the next cycle.
- EN written 1 at edge T: first prescaler count at T+1; with PRESCALE=0 counter = 1 after edge T+1.
- Match at tick edge T: MATCH=1 after T, irq=1 after T+1.
- rst mid-operation: all state to reset values at that edge, pending response dropped (ready=0 next cycle).

## Structure
- Package iob_timer_mc_pkg: register offset constants, CTRL bit indices, STATUS bit index, ADDR_W derivation function.
- Sub-module iob_timer_ch: one channel (prescaler, counter, compare, flags, register writes); top instantiates N_CH via generate, does address decode, read mux, ready and data_out registers.

## Test plan
- Reset: assert rst 2 cycles mid-count → all reads return 0, irq=0, ready=0 the cycle after rst.
- Periodic: ch0 PRESCALE=0, COMPARE=4, CTRL=EN|PERIODIC|IRQ_EN → counter sequence 0,1,2,3,4,0,…; MATCH at every 5th tick, irq[0] one cycle later; W1C on STATUS drops irq next cycle.
- One-shot with prescale: ch1 PRESCALE=2, COMPARE=3, CTRL=EN → counter steps every 3 cycles, holds at 3, CTRL reads EN=0, MATCH=1, irq[1]=0 (IRQ_EN=0).
- Wrap: COUNTER_WIDTH=16, COUNT=0xFFFE, COMPARE=1, periodic → 0xFFFF, 0x0000, 0x0001 then MATCH.
- Collisions: COUNT write on tick cycle → written value wins; STATUS clear on match cycle → MATCH stays 1; CLR write → counter 0, COMPARE retained.
- Bus: back-to-back reads of all channels/offsets incl. reserved and channel ≥ N_CH → ready each cycle, reserved/out-of-range read 0, independent channels do not interfere.

Source files
------------

// File: rtl/iob_timer_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_timer_mc_pkg
// Description : Register map, control/status bit positions and address width
//               helper shared by the multi-channel timer.
// Revision    : 1.0
// ============================================================================
package iob_timer_mc_pkg;

    localparam logic [2:0] C_OFF_CTRL     = 3'd0;
    localparam logic [2:0] C_OFF_COUNT    = 3'd1;
    localparam logic [2:0] C_OFF_COMPARE  = 3'd2;
    localparam logic [2:0] C_OFF_STATUS   = 3'd3;
    localparam logic [2:0] C_OFF_PRESCALE = 3'd4;

    localparam int C_CTRL_EN       = 0;
    localparam int C_CTRL_PERIODIC = 1;
    localparam int C_CTRL_IRQ_EN   = 2;
    localparam int C_CTRL_CLR      = 3;

    localparam int C_STATUS_MATCH  = 0;

    // Address is {channel index, 3-bit register offset}.
    function automatic int addr_w(input int n_ch);
        return $clog2(n_ch) + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_timer_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : iob_timer_mc_if
// Description : IOb native valid/ready bus plus per-channel interrupt lines.
// Revision    : 1.0
// ============================================================================
interface iob_timer_mc_if
    import iob_timer_mc_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int COUNTER_WIDTH = 32
);
    localparam int ADDR_W = addr_w(N_CH);

    logic                     valid;
    logic [ADDR_W-1:0]        addr;
    logic                     wr;
    logic [COUNTER_WIDTH-1:0] data_in;
    logic [COUNTER_WIDTH-1:0] data_out;
    logic                     ready;
    logic [N_CH-1:0]          irq;

    modport master (output valid, addr, wr, data_in, input  data_out, ready, irq);
    modport slave  (input  valid, addr, wr, data_in, output data_out, ready, irq);

endinterface
`default_nettype wire

// File: rtl/iob_timer_ch.sv
`default_nettype none
// ============================================================================
// Module      : iob_timer_ch
// Description : One timer channel: prescaler, counter, compare, sticky match
//               flag, registered interrupt and its register file.
// Revision    : 1.0
// ============================================================================
module iob_timer_ch
    import iob_timer_mc_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int PRESCALE_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [2:0]               reg_off,
    input  logic [COUNTER_WIDTH-1:0] wr_data,
    output logic [COUNTER_WIDTH-1:0] rd_data,
    output logic                     irq
);

    logic                     r_en;
    logic                     r_periodic;
    logic                     r_irq_en;
    logic                     r_match;
    logic                     r_irq;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic [COUNTER_WIDTH-1:0] r_compare;
    logic [PRESCALE_W-1:0]    r_presc_cnt;
    logic [PRESCALE_W-1:0]    r_prescale;

    logic w_tick;
    logic w_hit;
    logic w_wr_ctrl;
    logic w_wr_count;
    logic w_wr_compare;
    logic w_wr_status;
    logic w_wr_prescale;

    assign w_tick        = r_en && (r_presc_cnt == r_prescale);
    assign w_hit         = w_tick && (r_count == r_compare);
    assign w_wr_ctrl     = wr_en && (reg_off == C_OFF_CTRL);
    assign w_wr_count    = wr_en && (reg_off == C_OFF_COUNT);
    assign w_wr_compare  = wr_en && (reg_off == C_OFF_COMPARE);
    assign w_wr_status   = wr_en && (reg_off == C_OFF_STATUS);
    assign w_wr_prescale = wr_en && (reg_off == C_OFF_PRESCALE);

    // Bus writes come last so they override the same-cycle timer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en        <= 1'b0;
            r_periodic  <= 1'b0;
            r_irq_en    <= 1'b0;
            r_match     <= 1'b0;
            r_irq       <= 1'b0;
            r_count     <= '0;
            r_compare   <= '0;
            r_presc_cnt <= '0;
            r_prescale  <= '0;
        end else begin
            if (r_en) begin
                r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PRESCALE_W'(1);
            end
            if (w_tick) begin
                if (w_hit) begin
                    if (r_periodic) begin
                        r_count <= '0;
                    end else begin
                        r_en <= 1'b0;
                    end
                end else begin
                    r_count <= r_count + COUNTER_WIDTH'(1);
                end
            end
            r_irq <= r_match & r_irq_en;
            if (w_hit) begin
                r_match <= 1'b1;
            end else if (w_wr_status && wr_data[C_STATUS_MATCH]) begin
                r_match <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_en       <= wr_data[C_CTRL_EN];
                r_periodic <= wr_data[C_CTRL_PERIODIC];
                r_irq_en   <= wr_data[C_CTRL_IRQ_EN];
                if (wr_data[C_CTRL_CLR]) begin
                    r_count     <= '0;
                    r_presc_cnt <= '0;
                end
            end
            if (w_wr_count) begin
                r_count <= wr_data;
            end
            if (w_wr_compare) begin
                r_compare <= wr_data;
            end
            if (w_wr_prescale) begin
                r_prescale <= wr_data[PRESCALE_W-1:0];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_off)
            C_OFF_CTRL: begin
                rd_data[C_CTRL_EN]       = r_en;
                rd_data[C_CTRL_PERIODIC] = r_periodic;
                rd_data[C_CTRL_IRQ_EN]   = r_irq_en;
            end
            C_OFF_COUNT:    rd_data = r_count;
            C_OFF_COMPARE:  rd_data = r_compare;
            C_OFF_STATUS:   rd_data[C_STATUS_MATCH] = r_match;
            C_OFF_PRESCALE: rd_data = COUNTER_WIDTH'(r_prescale);
            default:        rd_data = '0;
        endcase
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: rtl/iob_timer_mc.sv
`default_nettype none
// ============================================================================
// Module      : iob_timer_mc
// Description : Multi-channel programmable timer on the IOb valid/ready bus.
// Revision    : 1.0
// ============================================================================
module iob_timer_mc
    import iob_timer_mc_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int COUNTER_WIDTH = 32,
    parameter int PRESCALE_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    iob_timer_mc_if.slave  bus
);

    localparam int ADDR_W = addr_w(N_CH);

    logic [ADDR_W-1:0]        w_ch_idx;
    logic [2:0]               w_off;
    logic [COUNTER_WIDTH-1:0] w_ch_rd [N_CH];
    logic [N_CH-1:0]          w_irq;
    logic [COUNTER_WIDTH-1:0] w_rd_mux;

    logic                     r_ready;
    logic [COUNTER_WIDTH-1:0] r_data_out;

    assign w_ch_idx = bus.addr >> 3;
    assign w_off    = bus.addr[2:0];

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic w_sel;
            assign w_sel = (w_ch_idx == ADDR_W'(i));

            iob_timer_ch #(
                .COUNTER_WIDTH (COUNTER_WIDTH),
                .PRESCALE_W    (PRESCALE_W)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (bus.valid && bus.wr && w_sel),
                .reg_off (w_off),
                .wr_data (bus.data_in),
                .rd_data (w_ch_rd[i]),
                .irq     (w_irq[i])
            );
        end
    endgenerate

    // Channel indices with no channel behind them fall through to zero.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_ch_idx == ADDR_W'(i)) begin
                w_rd_mux = w_ch_rd[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready    <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_ready <= bus.valid;
            if (bus.valid && !bus.wr) begin
                r_data_out <= w_rd_mux;
            end
        end
    end

    assign bus.ready    = r_ready;
    assign bus.data_out = r_data_out;
    assign bus.irq      = w_irq;

endmodule
`default_nettype wire
